// File: rtl/ans_ht_stf_sequencer_if.sv
// Signal bundle between the HT-STF sequencer, the TX controller, the
// generator and the downstream sample sink.
interface ans_ht_stf_sequencer_if;
  logic         tx_req;
  logic [127:0] tx_coeff;
  logic         tx_ack;
  logic         abort;
  logic         out_ready;
  logic         gen_reset;
  logic         gen_letsgo;
  logic         gen_givemeoutput;
  logic [127:0] gen_obf_coeff;
  logic [31:0]  gen_sample;
  logic         gen_started;
  logic [31:0]  stf_data;
  logic         stf_valid;
  logic         stf_last;
  logic         busy;
  logic         done;
  logic         timeout_err;

  modport master (
    input  tx_req, tx_coeff, abort, out_ready, gen_sample, gen_started,
    output tx_ack, gen_reset, gen_letsgo, gen_givemeoutput, gen_obf_coeff,
           stf_data, stf_valid, stf_last, busy, done, timeout_err
  );

  modport slave (
    output tx_req, tx_coeff, abort, out_ready, gen_sample, gen_started,
    input  tx_ack, gen_reset, gen_letsgo, gen_givemeoutput, gen_obf_coeff,
           stf_data, stf_valid, stf_last, busy, done, timeout_err
  );
endinterface

// File: rtl/ans_ht_stf_sequencer.sv
// Sequences one HT-STF generator run per request: reset, boot, prep wait,
// gated output enable, then a framed burst of NUM_SAMPLES samples.
module ans_ht_stf_sequencer #(
  parameter int NUM_SAMPLES    = 80,
  parameter int RST_CYCLES     = 2,
  parameter int PREP_CYCLES    = 340,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  ans_ht_stf_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRST, S_BOOT, S_PREP, S_WAIT_OUT, S_STREAM, S_DONE
  } state_t;

  state_t         r_state, w_state_next;
  logic [15:0]    r_cnt, w_cnt_next;
  logic [7:0]     r_smp, w_smp_next;
  logic [127:0]   r_coeff, w_coeff_next;
  logic [31:0]    r_stf_data, w_stf_data_next;
  logic           r_tx_ack, w_tx_ack_next;
  logic           r_gen_reset, w_gen_reset_next;
  logic           r_gen_letsgo, w_gen_letsgo_next;
  logic           r_gmo, w_gmo_next;
  logic           r_stf_valid, w_stf_valid_next;
  logic           r_stf_last, w_stf_last_next;
  logic           r_done, w_done_next;
  logic           r_timeout, w_timeout_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_smp        <= '0;
      r_coeff      <= '0;
      r_stf_data   <= '0;
      r_tx_ack     <= 1'b0;
      r_gen_reset  <= 1'b0;
      r_gen_letsgo <= 1'b0;
      r_gmo        <= 1'b0;
      r_stf_valid  <= 1'b0;
      r_stf_last   <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_smp        <= w_smp_next;
      r_coeff      <= w_coeff_next;
      r_stf_data   <= w_stf_data_next;
      r_tx_ack     <= w_tx_ack_next;
      r_gen_reset  <= w_gen_reset_next;
      r_gen_letsgo <= w_gen_letsgo_next;
      r_gmo        <= w_gmo_next;
      r_stf_valid  <= w_stf_valid_next;
      r_stf_last   <= w_stf_last_next;
      r_done       <= w_done_next;
      r_timeout    <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_smp_next        = r_smp;
    w_coeff_next      = r_coeff;
    w_stf_data_next   = r_stf_data;
    w_tx_ack_next     = 1'b0;
    w_gen_reset_next  = 1'b0;
    w_gen_letsgo_next = 1'b0;
    w_gmo_next        = r_gmo;
    w_stf_valid_next  = 1'b0;
    w_stf_last_next   = 1'b0;
    w_done_next       = 1'b0;
    w_timeout_next    = 1'b0;

    // Abort outranks every in-flight event, including the final sample and done.
    if (r_state != S_IDLE && bus.abort) begin
      w_state_next     = S_IDLE;
      w_gen_reset_next = 1'b1;
      w_gmo_next       = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.tx_req) begin
            w_coeff_next     = bus.tx_coeff;
            w_tx_ack_next    = 1'b1;
            w_gen_reset_next = 1'b1;
            w_cnt_next       = '0;
            w_state_next     = S_GRST;
          end
        end
        S_GRST: begin
          if (r_cnt == 16'(RST_CYCLES - 1)) begin
            w_gen_letsgo_next = 1'b1;
            w_state_next      = S_BOOT;
          end else begin
            w_gen_reset_next = 1'b1;
            w_cnt_next       = r_cnt + 16'd1;
          end
        end
        S_BOOT: begin
          w_cnt_next   = '0;
          w_state_next = S_PREP;
        end
        S_PREP: begin
          if (r_cnt == 16'(PREP_CYCLES - 1)) begin
            w_cnt_next   = '0;
            w_state_next = S_WAIT_OUT;
          end else begin
            w_cnt_next = r_cnt + 16'd1;
          end
        end
        S_WAIT_OUT: begin
          // Output enable is raised once and then the timeout window runs.
          if (!r_gmo) begin
            if (bus.out_ready) begin
              w_gmo_next = 1'b1;
              w_cnt_next = '0;
            end
          end else if (bus.gen_started) begin
            w_stf_data_next  = bus.gen_sample;
            w_stf_valid_next = 1'b1;
            w_smp_next       = '0;
            w_state_next     = S_STREAM;
          end else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            w_timeout_next   = 1'b1;
            w_gen_reset_next = 1'b1;
            w_gmo_next       = 1'b0;
            w_state_next     = S_IDLE;
          end else begin
            w_cnt_next = r_cnt + 16'd1;
          end
        end
        S_STREAM: begin
          w_stf_data_next  = bus.gen_sample;
          w_stf_valid_next = 1'b1;
          if (r_smp < 8'(NUM_SAMPLES - 1)) w_smp_next = r_smp + 8'd1;
          if (r_smp == 8'(NUM_SAMPLES - 2)) begin
            w_stf_last_next = 1'b1;
            w_state_next    = S_DONE;
          end
        end
        S_DONE: begin
          w_gmo_next   = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign bus.tx_ack           = r_tx_ack;
  assign bus.gen_reset        = r_gen_reset;
  assign bus.gen_letsgo       = r_gen_letsgo;
  assign bus.gen_givemeoutput = r_gmo;
  assign bus.gen_obf_coeff    = r_coeff;
  assign bus.stf_data         = r_stf_data;
  assign bus.stf_valid        = r_stf_valid;
  assign bus.stf_last         = r_stf_last;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.done             = r_done;
  assign bus.timeout_err      = r_timeout;

endmodule

// File: tb/tb_ans_ht_stf_sequencer.sv
// Bench for ans_ht_stf_sequencer: a table of burst scenarios plus randomized
// bursts, each measured cycle-by-cycle and checked against the burst rules.
`timescale 1ns/1ps
module tb_ans_ht_stf_sequencer;
  localparam int NS   = 80;
  localparam int PREP = 340;
  localparam int TO   = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  ans_ht_stf_sequencer_if bus();

  ans_ht_stf_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] coeff;
    int ready_delay;   // cycles after gen_letsgo before out_ready rises (0: already high)
    int start_delay;   // enable cycles before gen_started (-1: never)
    int abort_at;      // raise abort after this many valid samples (-1: never)
    int rst_at;        // drop rstn this many cycles after gen_letsgo (-1: never)
    bit toggle;
    bit drop_ready;
    int exp_valid;
    bit exp_last;
    bit exp_done;
    bit exp_to;
    int exp_rst;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int out_ones();
    return $countones({bus.tx_ack, bus.gen_reset, bus.gen_letsgo, bus.gen_givemeoutput,
                       bus.gen_obf_coeff, bus.stf_data, bus.stf_valid, bus.stf_last,
                       bus.busy, bus.done, bus.timeout_err});
  endfunction

  function automatic vec_t mk(input logic [127:0] c, input int rd, input int sd, input int ab,
                              input int ra, input bit tg, input bit dr, input int ev,
                              input bit el, input bit ed, input bit et, input int er);
    vec_t v;
    v.coeff = c; v.ready_delay = rd; v.start_delay = sd; v.abort_at = ab; v.rst_at = ra;
    v.toggle = tg; v.drop_ready = dr; v.exp_valid = ev; v.exp_last = el; v.exp_done = ed;
    v.exp_to = et; v.exp_rst = er;
    return v;
  endfunction

  // Reference rules: a burst yields NS samples unless aborted after k samples;
  // an abort costs one extra gen_reset cycle and suppresses done.
  function automatic vec_t mk_rand();
    vec_t v;
    v.coeff       = {$urandom(), $urandom(), $urandom(), $urandom()};
    v.ready_delay = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 700)) : 0;
    v.start_delay = int'($urandom_range(0, 900));
    v.abort_at    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NS)) : -1;
    v.rst_at      = -1;
    v.toggle      = 1'($urandom_range(0, 1));
    v.drop_ready  = 1'($urandom_range(0, 1));
    v.exp_valid   = (v.abort_at > 0) ? v.abort_at : NS;
    v.exp_last    = (v.exp_valid == NS);
    v.exp_done    = (v.abort_at < 0);
    v.exp_to      = 1'b0;
    v.exp_rst     = (v.abort_at > 0) ? 3 : 2;
    return v;
  endfunction

  task automatic run_burst(input vec_t v, input int idx, input bit hold,
                           output int ack_cyc, output int end_cyc);
    string p;
    int gmo_cnt = 0, si = 0, rdy_drv = -1, budget = 0;
    int n_ack = 0, c_ack = -1, n_rst = 0, c_rst0 = -1, n_go = 0, c_go = -1, c_gmo = -1;
    int n_valid = 0, c_v0 = -1, gaps = 0, data_bad = 0, n_last = 0, c_last = -1;
    int n_done = 0, c_done = -1, n_to = 0, c_to = -1, coeff_bad = 0, busy_bad = 0;
    bit rst_at_to = 0, started = 0, aborted = 0, accepted = 0, fin = 0, rdy_up = 0;
    bit prev_valid = 0, end_gmo = 0, end_valid = 0, did_rst = 0;
    logic [31:0] smp;
    p = $sformatf("v%0d", idx);
    exp_q.delete();
    rdy_up = (v.ready_delay == 0);
    bus.tx_req = 1'b1; bus.tx_coeff = v.coeff; bus.abort = 1'b0;
    bus.gen_started = 1'b0; bus.out_ready = rdy_up;
    while (!fin) begin
      tick();
      budget++;
      if (bus.tx_ack) begin
        n_ack++;
        if (!accepted) begin c_ack = cyc; if (!bus.busy) busy_bad++; end
        accepted = 1;
      end
      if (accepted) begin
        if (bus.gen_reset) begin n_rst++; if (c_rst0 < 0) c_rst0 = cyc; end
        if (bus.gen_letsgo) begin n_go++; c_go = cyc; end
        if (bus.gen_givemeoutput) begin if (c_gmo < 0) c_gmo = cyc; gmo_cnt++; end
        if (bus.stf_valid) begin
          if (n_valid == 0) c_v0 = cyc; else if (!prev_valid) gaps++;
          n_valid++;
          if (exp_q.size() == 0) data_bad++;
          else begin smp = exp_q.pop_front(); if (bus.stf_data !== smp) data_bad++; end
        end
        prev_valid = bus.stf_valid;
        if (bus.stf_last) begin n_last++; c_last = cyc; end
        if (bus.done) begin n_done++; c_done = cyc; end
        if (bus.timeout_err) begin n_to++; c_to = cyc; if (bus.gen_reset) rst_at_to = 1; end
        if (bus.gen_obf_coeff !== v.coeff) coeff_bad++;
        if (!bus.busy) begin fin = 1; end_gmo = bus.gen_givemeoutput; end_valid = bus.stf_valid; end
        if (v.rst_at >= 0 && c_go >= 0 && cyc == c_go + v.rst_at) begin
          #2 rstn = 1'b0;
          #1;
          check({p, "_async_zero"}, out_ones(), 0);
          fin = 1; did_rst = 1;
        end
      end
      if (budget > 4000) begin
        bad++; total++;
        $display("FAIL %s_budget: burst still running after %0d cycles, required end within 4000", p, budget);
        fin = 1;
      end
      if (!fin) begin
        if (accepted && !hold) bus.tx_req = 1'b0;
        bus.tx_coeff = (v.toggle && accepted) ? {$urandom(), $urandom(), $urandom(), $urandom()} : v.coeff;
        if (!rdy_up && c_go >= 0 && cyc >= c_go + v.ready_delay) begin
          bus.out_ready = 1'b1; rdy_up = 1; rdy_drv = cyc;
        end
        if (v.drop_ready && n_valid >= 10) bus.out_ready = 1'b0;
        bus.gen_started = 1'b0;
        if (v.start_delay >= 0 && !started && bus.gen_givemeoutput && gmo_cnt == v.start_delay + 1) begin
          bus.gen_started = 1'b1; started = 1;
        end
        smp = $urandom();
        bus.gen_sample = smp;
        if (started && si < NS) begin exp_q.push_back(smp); si++; end
        bus.abort = 1'b0;
        if (v.abort_at > 0 && !aborted && n_valid == v.abort_at) begin bus.abort = 1'b1; aborted = 1; end
      end
    end
    ack_cyc = c_ack;
    end_cyc = cyc;
    if (did_rst) begin
      bus.tx_req = 1'b0; bus.abort = 1'b0; bus.gen_started = 1'b0; bus.out_ready = 1'b0;
      tick();
      check({p, "_held_zero"}, out_ones(), 0);
      #2 rstn = 1'b1;
    end else if (budget <= 4000) begin
      check({p, "_ack_n"}, n_ack, 1);
      check({p, "_busy_at_ack"}, busy_bad, 0);
      check({p, "_rst_first"}, c_rst0 - c_ack, 0);
      check({p, "_rst_n"}, n_rst, v.exp_rst);
      check({p, "_go_at"}, c_go - c_ack, 2);
      check({p, "_go_n"}, n_go, 1);
      check({p, "_gmo_prep_ok"}, (c_gmo - c_go) >= PREP + 1, 1);
      if (v.ready_delay > 0) check({p, "_gmo_after_ready"}, c_gmo > rdy_drv, 1);
      check({p, "_valid_n"}, n_valid, v.exp_valid);
      check({p, "_valid_gaps"}, gaps, 0);
      check({p, "_data_bad"}, data_bad, 0);
      check({p, "_last_n"}, n_last, v.exp_last);
      if (v.exp_last) check({p, "_last_at"}, c_last - c_v0, NS - 1);
      check({p, "_done_n"}, n_done, v.exp_done);
      if (v.exp_done) check({p, "_done_at"}, c_done - c_last, 1);
      check({p, "_to_n"}, n_to, v.exp_to);
      if (v.exp_to) begin
        check({p, "_to_at"}, c_to - c_gmo, TO);
        check({p, "_to_rst"}, rst_at_to, 1);
      end
      check({p, "_coeff_bad"}, coeff_bad, 0);
      check({p, "_end_gmo"}, end_gmo, 0);
      check({p, "_end_valid"}, end_valid, 0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    vec_t rv;
    int a_c, e_c;
    int h_ack[3], h_end[3];
    logic [127:0] cf;
    cf = {112'd0, 16'h05AF};

    tbl[0]  = mk(128'd0, 0, 3, -1, -1, 0, 0, 80, 1, 1, 0, 2);
    tbl[1]  = mk(cf, 0, 1, -1, -1, 1, 0, 80, 1, 1, 0, 2);
    tbl[2]  = mk(128'hA5A5_0001, 600, 5, -1, -1, 0, 1, 80, 1, 1, 0, 2);
    tbl[3]  = mk(128'h77, 0, -1, -1, -1, 0, 0, 0, 0, 0, 1, 3);
    tbl[4]  = mk(128'h1234, 0, 2, 40, -1, 0, 0, 40, 0, 0, 0, 3);
    tbl[5]  = mk(128'hBEEF, 0, 0, -1, -1, 0, 0, 80, 1, 1, 0, 2);
    tbl[6]  = mk(128'h9, 0, 4, 79, -1, 0, 0, 79, 0, 0, 0, 3);
    tbl[7]  = mk(128'hA, 0, 4, 80, -1, 0, 0, 80, 1, 0, 0, 3);
    tbl[8]  = mk(128'hC0FFEE, 0, 1000, -1, -1, 0, 0, 80, 1, 1, 0, 2);
    tbl[9]  = mk({4{32'hDEAD_BEEF}}, 0, 0, -1, 100, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk({4{32'h0F0F_1234}}, 0, 0, -1, 380, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(128'h5, 0, 2, -1, -1, 0, 0, 80, 1, 1, 0, 2);

    bus.tx_req = 1'b0; bus.tx_coeff = '0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    bus.gen_sample = '0; bus.gen_started = 1'b0;
    tick();
    tick();
    check("reset_outputs_zero", out_ones(), 0);
    #2 rstn = 1'b1;
    tick();
    check("post_reset_idle", bus.busy, 0);

    for (int i = 0; i < 12; i++) run_burst(tbl[i], i, 1'b0, a_c, e_c);

    for (int i = 0; i < 6; i++) begin
      rv = mk_rand();
      run_burst(rv, 100 + i, 1'b0, a_c, e_c);
    end

    // tx_req held high: one acceptance per burst, one IDLE cycle between bursts
    for (int i = 0; i < 3; i++) run_burst(tbl[0], 200 + i, 1'b1, h_ack[i], h_end[i]);
    bus.tx_req = 1'b0;
    for (int i = 1; i < 3; i++) begin
      check($sformatf("hold%0d_duration", i), h_end[i] - h_ack[i], h_end[0] - h_ack[0]);
      check($sformatf("hold%0d_reaccept", i), h_ack[i] - h_end[i - 1], 1);
    end
    tick();
    check("hold_released_idle", bus.busy, 0);

    // abort alone in IDLE is ignored
    bus.abort = 1'b1;
    tick();
    check("idle_abort_busy", bus.busy, 0);
    check("idle_abort_rst", bus.gen_reset, 0);
    // abort together with tx_req in IDLE: request wins
    bus.tx_req = 1'b1; bus.tx_coeff = 128'h4321;
    tick();
    check("abort_req_ack", bus.tx_ack, 1);
    check("abort_req_busy", bus.busy, 1);
    check("abort_req_coeff", bus.gen_obf_coeff, 128'h4321);
    // abort still high in GRST now cancels the burst
    bus.tx_req = 1'b0;
    tick();
    check("grst_abort_busy", bus.busy, 0);
    check("grst_abort_rst", bus.gen_reset, 1);
    check("grst_abort_ack", bus.tx_ack, 0);
    bus.abort = 1'b0;
    tick();
    check("grst_abort_rst_once", bus.gen_reset, 0);
    check("grst_abort_letsgo", bus.gen_letsgo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
